// File: rtl/uart_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// uart_fifo_ctrl
//   Pointer and drain controller for the UART transmit FIFO. It owns the write
//   and read pointers of an external synchronous dual-port RAM (depth
//   2^ADDR_W). Full and empty come from comparing the pointers together with
//   their wrap bits. Stored bytes are handed to the UART transmitter through a
//   start/busy handshake.
//
//   Optional build macro: UART_FIFO_OVF_EN
//     defined   : overflow is a sticky flag, set by a write while full and
//                 cleared by clr_ovf (a set in the same cycle wins).
//     undefined : overflow is tied low and clr_ovf is ignored. Writes made
//                 while full are still dropped.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   wr_en      producer write request (one byte per cycle)
//   wr_data    producer byte
//   ram_we     RAM write enable (wr_en & !full), combinational
//   ram_waddr  RAM write address (write pointer without wrap bit)
//   ram_wdata  RAM write data (wr_data pass-through)
//   ram_raddr  RAM read address (read pointer without wrap bit)
//   ram_rdata  RAM read data, valid one cycle after the address
//   tx_start   one-cycle pulse: tx_data is valid, begin transmission
//   tx_data    registered byte for the transmitter
//   tx_busy    transmitter busy; rises the cycle after tx_start
//   full       FIFO full
//   empty      FIFO empty
//   count      number of stored bytes, 0..2^ADDR_W (registered)
//   overflow   sticky flag: write attempted while full
//   clr_ovf    synchronous clear of overflow
// -----------------------------------------------------------------------------
module uart_fifo_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  input  logic              clr_ovf
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_LOAD = 2'd2,
    ST_WAIT = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_r;
  state_t              state_nxt_s;
  logic [ADDR_W:0]     wptr_r;
  logic [ADDR_W:0]     rptr_r;
  logic [ADDR_W:0]     wptr_nxt_s;
  logic [ADDR_W:0]     rptr_nxt_s;
  logic [ADDR_W:0]     count_r;
  logic                full_s;
  logic                empty_s;
  logic                wr_ok_s;
  logic                rd_adv_s;
  logic                load_s;
  logic                tx_start_r;
  logic [DATA_W-1:0]   tx_data_r;

  // The MSB is the wrap bit. Equal pointers mean empty. Equal addresses with
  // different wrap bits mean full.
  assign empty_s = (wptr_r == rptr_r);
  assign full_s  = (wptr_r[ADDR_W-1:0] == rptr_r[ADDR_W-1:0]) &&
                   (wptr_r[ADDR_W] != rptr_r[ADDR_W]);
  assign wr_ok_s = wr_en & ~full_s;

  assign ram_we    = wr_ok_s;
  assign ram_waddr = wptr_r[ADDR_W-1:0];
  assign ram_wdata = wr_data;
  assign ram_raddr = rptr_r[ADDR_W-1:0];
  assign full      = full_s;
  assign empty     = empty_s;
  assign count     = count_r;
  assign tx_start  = tx_start_r;
  assign tx_data   = tx_data_r;

  // Drain FSM: next-state logic and the read-advance / load strobes.
  always_comb begin
    state_nxt_s = state_r;
    rd_adv_s    = 1'b0;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && !tx_busy) begin
          state_nxt_s = ST_READ;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      // The RAM samples ram_raddr at this edge, so rptr can advance here.
      ST_READ: begin
        state_nxt_s = ST_LOAD;
        rd_adv_s    = 1'b1;
      end
      ST_LOAD: begin
        state_nxt_s = ST_WAIT;
        load_s      = 1'b1;
      end
      // Wait for the transmitter to accept the byte before going back to IDLE.
      ST_WAIT: begin
        if (tx_busy) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Next pointer values. Full is decoded from the pointers before the edge, so
  // a write that meets a read advance while full is still rejected.
  always_comb begin
    wptr_nxt_s = wptr_r;
    rptr_nxt_s = rptr_r;
    if (wr_ok_s) begin
      wptr_nxt_s = wptr_r + PTR_ONE;
    end else begin
      wptr_nxt_s = wptr_r;
    end
    if (rd_adv_s) begin
      rptr_nxt_s = rptr_r + PTR_ONE;
    end else begin
      rptr_nxt_s = rptr_r;
    end
  end

  // State, pointers and registered occupancy count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      wptr_r  <= {(ADDR_W+1){1'b0}};
      rptr_r  <= {(ADDR_W+1){1'b0}};
      count_r <= {(ADDR_W+1){1'b0}};
    end else begin
      state_r <= state_nxt_s;
      wptr_r  <= wptr_nxt_s;
      rptr_r  <= rptr_nxt_s;
      count_r <= wptr_nxt_s - rptr_nxt_s;
    end
  end

  // Transmitter handoff: capture the RAM byte and pulse tx_start for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_start_r <= 1'b0;
      tx_data_r  <= {DATA_W{1'b0}};
    end else begin
      tx_start_r <= load_s;
      if (load_s) begin
        tx_data_r <= ram_rdata;
      end else begin
        tx_data_r <= tx_data_r;
      end
    end
  end

`ifdef UART_FIFO_OVF_EN
  logic ovf_r;

  // Sticky overflow flag. A set in the same cycle as clr_ovf takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_r <= 1'b0;
    end else if (wr_en && full_s) begin
      ovf_r <= 1'b1;
    end else if (clr_ovf) begin
      ovf_r <= 1'b0;
    end else begin
      ovf_r <= ovf_r;
    end
  end

  assign overflow = ovf_r;
`else
  logic unused_clr_ovf_s;

  assign unused_clr_ovf_s = clr_ovf;
  assign overflow         = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_fifo_ctrl
//   Self-checking bench for uart_fifo_ctrl. It models the synchronous RAM and a
//   transmitter that stays busy for busy_len cycles. Accepted bytes are pushed
//   to exp_q, and the bytes seen on tx_start pulses are collected in obs_q for
//   in-order comparison.
// -----------------------------------------------------------------------------
module tb_uart_fifo_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       ram_we;
  logic [3:0] ram_waddr;
  logic [7:0] ram_wdata;
  logic [3:0] ram_raddr;
  logic [7:0] ram_rdata;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       clr_ovf;

  int n_pass;
  int n_total;

`ifdef UART_FIFO_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  uart_fifo_ctrl #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous dual-port RAM with one cycle of read latency.
  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  // Transmitter: busy for busy_len cycles starting the cycle after tx_start.
  int   busy_cnt;
  int   busy_len;
  logic hold_busy;
  always @(posedge clk or posedge rst) begin
    if (rst) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= busy_len;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = hold_busy | (busy_cnt != 0);

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard queues: expected bytes, observed bytes, observed pulse cycles.
  logic [7:0] exp_q [$];
  logic [7:0] obs_q [$];
  int         obs_t [$];
  always @(negedge clk) begin
    if (tx_start === 1'b1) begin
      obs_q.push_back(tx_data);
      obs_t.push_back(cyc);
    end
  end

  logic [4:0] m_wptr;

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; clr_ovf = 1'b0; hold_busy = 1'b0;
    busy_len = 10; m_wptr = 5'd0;
    repeat (3) @(negedge clk);
    n_total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
    n_total++; if (count !== 5'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else n_pass++;
    n_total++; if (tx_start !== 1'b0) $display("FAIL reset_txstart: got %b want 0", tx_start); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL reset_txdata: got %h want 00", tx_data); else n_pass++;
    n_total++; if (ram_we !== 1'b0) $display("FAIL reset_ramwe: got %b want 0", ram_we); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'hA5; #1;
    n_total++; if (ram_we !== 1'b1) $display("FAIL single_ramwe: got %b want 1", ram_we); else n_pass++;
    n_total++; if (ram_waddr !== m_wptr[3:0]) $display("FAIL single_waddr: got %0d want %0d", ram_waddr, m_wptr[3:0]); else n_pass++;
    n_total++; if (ram_wdata !== 8'hA5) $display("FAIL single_wdata: got %h want a5", ram_wdata); else n_pass++;
    exp_q.push_back(8'hA5); m_wptr++;
    @(negedge clk); wr_en = 1'b0;
    n_total++; if (count !== 5'd1) $display("FAIL single_count_n: got %0d want 1", count); else n_pass++;
    n_total++; if (empty !== 1'b0) $display("FAIL single_empty_n: got %b want 0", empty); else n_pass++;
    @(negedge clk);
    n_total++; if (count !== 5'd1) $display("FAIL single_count_n1: got %0d want 1", count); else n_pass++;
    n_total++; if (tx_start !== 1'b0) $display("FAIL single_early_start: got %b want 0", tx_start); else n_pass++;
    @(negedge clk);
    n_total++; if (count !== 5'd0) $display("FAIL single_count_n2: got %0d want 0", count); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL single_empty_n2: got %b want 1", empty); else n_pass++;
    n_total++; if (tx_start !== 1'b0) $display("FAIL single_start_n2: got %b want 0", tx_start); else n_pass++;
    @(negedge clk);
    n_total++; if (tx_start !== 1'b1) $display("FAIL single_start_n3: got %b want 1", tx_start); else n_pass++;
    n_total++; if (tx_data !== 8'hA5) $display("FAIL single_txdata: got %h want a5", tx_data); else n_pass++;
    @(negedge clk);
    n_total++; if (tx_start !== 1'b0) $display("FAIL single_pulse_width: got %b want 0", tx_start); else n_pass++;
    repeat (busy_len + 5) @(negedge clk);
    n_total++; if (obs_q.size() != 1) $display("FAIL single_obs_count: got %0d want 1", obs_q.size()); else n_pass++;
    if (obs_q.size() > 0 && exp_q.size() > 0) begin
      n_total++; if (obs_q[0] !== exp_q[0]) $display("FAIL single_sb: got %h want %h", obs_q[0], exp_q[0]); else n_pass++;
    end
    obs_q.delete(); obs_t.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_drain();
    @(negedge clk);
    wr_en = 1'b1; wr_data = 8'h3C;
    @(negedge clk); wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1; #1;
    n_total++; if (tx_start !== 1'b0) $display("FAIL mid_rst_start: got %b want 0", tx_start); else n_pass++;
    n_total++; if (tx_data !== 8'h00) $display("FAIL mid_rst_txdata: got %h want 00", tx_data); else n_pass++;
    n_total++; if (count !== 5'd0) $display("FAIL mid_rst_count: got %0d want 0", count); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL mid_rst_empty: got %b want 1", empty); else n_pass++;
    n_total++; if (ram_raddr !== 4'd0) $display("FAIL mid_rst_raddr: got %0d want 0", ram_raddr); else n_pass++;
    m_wptr = 5'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    n_total++; if (obs_q.size() != 0) $display("FAIL mid_rst_no_start: got %0d pulses want 0", obs_q.size()); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL mid_rst_empty_after: got %b want 1", empty); else n_pass++;
    obs_q.delete(); obs_t.delete();
  endtask

  task automatic test_fill_overflow();
    hold_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i); #1;
      n_total++; if (ram_we !== 1'b1) $display("FAIL fill_ramwe_%0d: got %b want 1", i, ram_we); else n_pass++;
      n_total++; if (ram_waddr !== m_wptr[3:0]) $display("FAIL fill_waddr_%0d: got %0d want %0d", i, ram_waddr, m_wptr[3:0]); else n_pass++;
      exp_q.push_back(8'(i)); m_wptr++;
      @(negedge clk);
    end
    wr_en = 1'b0;
    n_total++; if (full !== 1'b1) $display("FAIL fill_full: got %b want 1", full); else n_pass++;
    n_total++; if (count !== 5'd16) $display("FAIL fill_count: got %0d want 16", count); else n_pass++;
    n_total++; if (empty !== 1'b0) $display("FAIL fill_empty: got %b want 0", empty); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL fill_ovf_pre: got %b want 0", overflow); else n_pass++;
    wr_en = 1'b1; wr_data = 8'hFF; #1;
    n_total++; if (ram_we !== 1'b0) $display("FAIL ovf_ramwe: got %b want 0", ram_we); else n_pass++;
    @(negedge clk); wr_en = 1'b0;
    n_total++; if (overflow !== OVF_EXP) $display("FAIL ovf_flag: got %b want %b", overflow, OVF_EXP); else n_pass++;
    n_total++; if (count !== 5'd16) $display("FAIL ovf_count: got %0d want 16", count); else n_pass++;
    n_total++; if (full !== 1'b1) $display("FAIL ovf_full: got %b want 1", full); else n_pass++;
  endtask

  task automatic test_full_same_edge();
    hold_busy = 1'b0;
    @(negedge clk);
    // The FSM is in READ now, so rptr advances on the coming edge.
    wr_en = 1'b1; wr_data = 8'hEE; #1;
    n_total++; if (ram_we !== 1'b0) $display("FAIL same_edge_ramwe: got %b want 0", ram_we); else n_pass++;
    @(negedge clk); wr_en = 1'b0;
    n_total++; if (count !== 5'd15) $display("FAIL same_edge_count: got %0d want 15", count); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL same_edge_full: got %b want 0", full); else n_pass++;
    wr_en = 1'b1; wr_data = 8'h10; #1;
    n_total++; if (ram_we !== 1'b1) $display("FAIL refill_ramwe: got %b want 1", ram_we); else n_pass++;
    n_total++; if (ram_waddr !== m_wptr[3:0]) $display("FAIL refill_waddr: got %0d want %0d", ram_waddr, m_wptr[3:0]); else n_pass++;
    exp_q.push_back(8'h10); m_wptr++;
    @(negedge clk); wr_en = 1'b0;
    n_total++; if (count !== 5'd16) $display("FAIL refill_count: got %0d want 16", count); else n_pass++;
    n_total++; if (full !== 1'b1) $display("FAIL refill_full: got %b want 1", full); else n_pass++;
    // Write while full together with clr_ovf: the set must win.
    wr_en = 1'b1; wr_data = 8'hDD; clr_ovf = 1'b1;
    @(negedge clk); wr_en = 1'b0;
    n_total++; if (overflow !== OVF_EXP) $display("FAIL ovf_set_wins: got %b want %b", overflow, OVF_EXP); else n_pass++;
    n_total++; if (count !== 5'd16) $display("FAIL ovf_set_count: got %0d want 16", count); else n_pass++;
    @(negedge clk); clr_ovf = 1'b0;
    n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_drain();
    int  k;
    bit  done;
    done = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (obs_q.size() >= exp_q.size() && empty === 1'b1 && busy_cnt == 0) begin
        done = 1'b1;
        break;
      end
    end
    n_total++; if (!done) $display("FAIL drain_timeout: got %0d bytes want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL drain_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    k = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      logic [7:0] e;
      logic [7:0] o;
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_total++; if (o !== e) $display("FAIL drain_byte_%0d: got %h want %h", k, o, e); else n_pass++;
      k++;
    end
    // With the FIFO never running dry, pulses are spaced 3 + busy_len + 1 cycles.
    for (int i = 1; i < obs_t.size(); i++) begin
      n_total++;
      if (obs_t[i] - obs_t[i-1] != 3 + busy_len + 1)
        $display("FAIL drain_spacing_%0d: got %0d want %0d", i, obs_t[i] - obs_t[i-1], 3 + busy_len + 1);
      else n_pass++;
    end
    obs_t.delete();
    n_total++; if (empty !== 1'b1) $display("FAIL drain_empty: got %b want 1", empty); else n_pass++;
    n_total++; if (count !== 5'd0) $display("FAIL drain_count: got %0d want 0", count); else n_pass++;
    repeat (20) @(negedge clk);
    n_total++; if (obs_q.size() != 0) $display("FAIL drain_spurious: got %0d pulses want 0", obs_q.size()); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    cyc = 0;
    test_reset();
    test_single();
    test_reset_mid_drain();
    test_fill_overflow();
    test_full_same_edge();
    test_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_fifo_ctrl.md
# uart_fifo_ctrl

Pointer and drain controller for the UART transmit FIFO. Owns the write and read pointers of an external synchronous dual-port RAM (depth 2^ADDR_W), derives full/empty from pointer-plus-wrap-bit comparison, and sequences stored bytes into the UART transmitter through a start/busy handshake. It sits between the host-side byte producer and the UART TX serializer.

## Interface
- ADDR_W, 4, RAM address width; FIFO depth = 2^ADDR_W (16)
- DATA_W, 8, byte width
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  producer write request, one byte per cycle
- wr_data  in  DATA_W  producer byte
- ram_we  out  1  RAM write enable = wr_en & !full (combinational)
- ram_waddr  out  ADDR_W  wptr[ADDR_W-1:0]
- ram_wdata  out  DATA_W  wr_data pass-through
- ram_raddr  out  ADDR_W  rptr[ADDR_W-1:0]
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after address
- tx_start  out  1  one-cycle pulse: tx_data valid, begin transmission
- tx_data  out  DATA_W  registered byte for the transmitter
- tx_busy  in  1  transmitter busy; rises the cycle after tx_start
- full  out  1  FIFO full
- empty  out  1  FIFO empty
- count  out  ADDR_W+1  bytes stored, 0..2^ADDR_W
- overflow  out  1  sticky: write attempted while full
- clr_ovf  in  1  synchronous clear of overflow

## Operation
- wptr, rptr are ADDR_W+1 bits; MSB is the wrap-state bit, toggling each pass through the RAM.
- empty = (wptr == rptr); full = (address bits equal) & (MSBs differ). Both decoded from registered pointers only.
- Write: ram_we asserted and wptr increments when wr_en & !full. wr_en & full: byte dropped, wptr unchanged, overflow set.
- count = wptr - rptr, modulo 2^(ADDR_W+1); registered.
- Drain FSM states IDLE, READ, LOAD, WAIT:
  - IDLE -> READ when !empty & !tx_busy; else stay.
  - READ -> LOAD unconditionally; ram_raddr holds rptr; rptr increments on this edge.
  - LOAD -> WAIT unconditionally; tx_data <= ram_rdata, tx_start <= 1 on this edge.
  - WAIT: tx_start deasserts after one cycle; -> IDLE when tx_busy = 1.
- Simultaneous write and rptr increment: both pointers advance, count unchanged.
- Write while full in the same cycle rptr increments: still rejected (full sampled from pre-edge pointers).
- overflow set and clr_ovf in the same cycle: set wins.
- Reset mid-operation: in-flight byte discarded, no tx_start issued.

## Timing
- Reset values: wptr = rptr = 0, empty = 1, full = 0, count = 0, overflow = 0, tx_start = 0, tx_data = 0, FSM = IDLE.
- Write on edge N into empty FIFO: empty = 0, count = 1 after edge N; READ after N+1; LOAD and count = 0 after N+2; tx_start = 1 with valid tx_data after N+3.
- Back-to-back bytes: minimum spacing between tx_start pulses = 3 cycles + transmitter busy duration + 1.
- Pointer wrap: address bits roll 2^ADDR_W-1 -> 0 with MSB toggle; no other effect.
- ram_we/ram_waddr/ram_wdata are combinational from wr_en, wr_data and registered state.

## Configuration
- UART_FIFO_OVF_EN defined: overflow sticky flag and clr_ovf behave as above.
- Not defined: overflow tied to 0, clr_ovf ignored, overflow register removed; rejected writes still drop silently.

## Test plan
- Reset: assert rst mid-drain -> all outputs at reset values immediately, no tx_start after release until new write.
- Single byte 0xA5 into empty FIFO at edge N, tx_busy idle -> tx_start pulse after N+3 with tx_data = 0xA5; count 1 -> 0 after N+2; empty = 1 after N+2.
- Hold tx_busy = 1, write 16 bytes 0x00..0x0F -> full = 1, count = 16; 17th write 0xFF -> ram_we = 0, overflow = 1, count stays 16.
- Release tx_busy, model busy 10 cycles per byte -> bytes 0x00..0x0F emitted in order, pointer wrap crossed without corruption, empty = 1 at end.
- While full, write and drain on same edge -> write rejected, count 16 -> 15; next cycle write accepted, count 16.
- clr_ovf with write-while-full on same edge -> overflow stays 1; clr_ovf alone -> overflow 0 (with UART_FIFO_OVF_EN); without macro overflow is always 0.
